sm83_clock_gen: RTL

Master-clock phase generator and run/stop sequencer for the SM83 core. It derives the nine phase clocks CLK1..CLK9 from a single 8x master clock, with eight master ticks per M-cycle. It gates the phases on oscillator stability and holds SYNC_RESET through power-up. It also freezes the phases on M-cycle boundaries when the core requests halt (CLK_ENA) or STOP (OSC_ENA). It sits between the board oscillator pad and SM83Core, driving every CLKx input and SYNC_RESET.

---
 rtl/sm83_clock_gen.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sm83_clock_gen.sv
// SM83 master-clock phase generator: derives CLK1..CLK9 from an 8x master clock,
// sequences power-up reset, and freezes phases on M-cycle boundaries for HALT/STOP.
module sm83_clock_gen #(
  parameter int unsigned STABLE_CYC = 16,
  parameter int unsigned RST_MCYC   = 4
) (
  input  logic CLK,
  input  logic nRESET,
  input  logic OSC_STABLE,
  input  logic OSC_ENA,
  input  logic CLK_ENA,
  input  logic WAKE,
  output logic CLK1,
  output logic CLK2,
  output logic CLK3,
  output logic CLK4,
  output logic CLK5,
  output logic CLK6,
  output logic CLK7,
  output logic CLK8,
  output logic CLK9,
  output logic SYNC_RESET,
  output logic RUNNING
);

  localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYC);
  localparam logic [7:0] MCYC_LIM   = 8'(RST_MCYC);

  typedef enum logic [2:0] {
    S_WAIT_OSC = 3'd0,
    S_RST_RUN  = 3'd1,
    S_RUN      = 3'd2,
    S_HOLD     = 3'd3,
    S_STOP     = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  ph_q, ph_d;
  logic [7:0]  stab_q, stab_d;
  logic [7:0]  mcyc_q, mcyc_d;
  logic [8:0]  clk_q, clk_d;
  logic        sync_q, sync_d;
  logic        run_q, run_d;

  // Bit k-1 of the result is CLKk for the given phase.
  function automatic logic [8:0] phase_decode(input logic [2:0] ph);
    logic [8:0] d;
    d[0] = (ph <= 3'd3);
    d[1] = (ph >= 3'd4);
    d[2] = (ph >= 3'd2) && (ph <= 3'd5);
    d[3] = (ph >= 3'd6) || (ph <= 3'd1);
    d[4] = (ph >= 3'd1) && (ph <= 3'd4);
    d[5] = (ph >= 3'd5) || (ph == 3'd0);
    d[6] = (ph >= 3'd3) && (ph <= 3'd6);
    d[7] = (ph[1:0] == 2'd0);
    d[8] = (ph[1:0] != 2'd0);
    return d;
  endfunction

  // Next-state, counter and output decode logic.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    stab_d  = stab_q;
    mcyc_d  = mcyc_q;
    sync_d  = sync_q;
    case (state_q)
      S_WAIT_OSC: begin
        if (!OSC_STABLE) begin
          stab_d = 8'd0;
        end else if (stab_q + 8'd1 == STABLE_LIM) begin
          stab_d  = 8'd0;
          ph_d    = 3'd0;
          // After a STOP wake-up the core is not reset again.
          state_d = sync_q ? S_RST_RUN : S_RUN;
        end else begin
          stab_d = stab_q + 8'd1;
        end
      end
      S_RST_RUN: begin
        ph_d = ph_q + 3'd1;
        if (ph_q == 3'd7) begin
          if (mcyc_q + 8'd1 == MCYC_LIM) begin
            mcyc_d  = 8'd0;
            sync_d  = 1'b0;
            state_d = S_RUN;
          end else begin
            mcyc_d = mcyc_q + 8'd1;
          end
        end else begin
          mcyc_d = mcyc_q;
        end
      end
      S_RUN: begin
        ph_d = ph_q + 3'd1;
        if (ph_q == 3'd7) begin
          if (!OSC_ENA) begin
            state_d = S_STOP;
          end else if (!CLK_ENA) begin
            state_d = S_HOLD;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_HOLD: begin
        ph_d = 3'd0;
        if (CLK_ENA) begin
          state_d = S_RUN;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_STOP: begin
        ph_d = 3'd0;
        if (WAKE) begin
          state_d = S_WAIT_OSC;
          stab_d  = 8'd0;
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d = S_WAIT_OSC;
        ph_d    = 3'd0;
        stab_d  = 8'd0;
        mcyc_d  = 8'd0;
        sync_d  = 1'b1;
      end
    endcase
    run_d = (state_d == S_RST_RUN) || (state_d == S_RUN);
    if (run_d) begin
      clk_d = phase_decode(ph_d);
    end else begin
      clk_d = 9'd0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      state_q <= S_WAIT_OSC;
      ph_q    <= 3'd0;
      stab_q  <= 8'd0;
      mcyc_q  <= 8'd0;
      clk_q   <= 9'd0;
      sync_q  <= 1'b1;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      stab_q  <= stab_d;
      mcyc_q  <= mcyc_d;
      clk_q   <= clk_d;
      sync_q  <= sync_d;
      run_q   <= run_d;
    end
  end

  assign CLK1       = clk_q[0];
  assign CLK2       = clk_q[1];
  assign CLK3       = clk_q[2];
  assign CLK4       = clk_q[3];
  assign CLK5       = clk_q[4];
  assign CLK6       = clk_q[5];
  assign CLK7       = clk_q[6];
  assign CLK8       = clk_q[7];
  assign CLK9       = clk_q[8];
  assign SYNC_RESET = sync_q;
  assign RUNNING    = run_q;

endmodule
